// File: rtl/max_pool2x2_if.sv
// -----------------------------------------------------------------------------
// max_pool2x2_if
// Stream bundle for the 2x2 max-pooling stage: one valid/ready input stream
// of convolution pixels and one valid/ready output stream of pooled pixels.
//
//   in_valid  : producer has a pixel on in_data
//   in_data   : unsigned pixel, raster order
//   in_ready  : pooling stage accepts in_data this cycle
//   out_valid : pooling stage has a pooled pixel on out_data
//   out_data  : unsigned pooled pixel, raster order
//   out_ready : consumer accepts out_data this cycle
//
// master = the environment (pixel producer + pooled-pixel consumer)
// slave  = the pooling stage itself
// -----------------------------------------------------------------------------
interface max_pool2x2_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/max_pool2x2.sv
// -----------------------------------------------------------------------------
// max_pool2x2
// Streaming 2x2 / stride-2 max pooling of a COLS x ROWS frame of unsigned
// pixels arriving in raster order. Even rows fold horizontal pairs into a
// line buffer; odd rows fold their pairs with the buffered value and emit
// one pooled pixel per tile. Sustains one input pixel per cycle.
//
// Ports:
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high, clears all state
//   start      : begin a frame (only looked at while idle)
//   busy       : high from accepted start until frame_done
//   frame_done : one-cycle pulse once the frame's last output has left
//   s          : stream bundle (in_valid/in_data/in_ready,
//                out_valid/out_data/out_ready)
// -----------------------------------------------------------------------------
module max_pool2x2 #(
    parameter int COLS   = 4,
    parameter int ROWS   = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    max_pool2x2_if.slave      s
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [3:0] COL_LAST = 4'(COLS - 1);
    localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
    localparam bit         COLS_ODD = (COLS % 2) == 1;

    function automatic logic [DATA_W-1:0] max2(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    state_t            state, state_next;
    logic [3:0]        row, row_next;
    logic [3:0]        col, col_next;
    logic              done_next;
    logic              frame_done_q;

    logic [DATA_W-1:0] pair_reg;
    logic [DATA_W-1:0] line_buf [8];

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    logic              in_rows;
    logic              in_ready_c;
    logic              accept;
    logic              last_col;
    logic              last_row;
    logic              orphan;
    logic              pair_wr;
    logic              lb_wr;
    logic              produce;
    logic [DATA_W-1:0] pair_max;
    logic [DATA_W-1:0] tile_max;

    // ---- stage p0: handshake decode and tile folding ----
    always_comb begin
        in_rows    = (state == EVEN_ROW) || (state == ODD_ROW);
        // No skid buffer: a stalled output blocks the input combinationally.
        in_ready_c = in_rows && (!vld_p1 || s.out_ready);
        accept     = s.in_valid && in_ready_c;
        last_col   = (col == COL_LAST);
        last_row   = (row == ROW_LAST);
        // With an odd width the last column has no partner and is dropped.
        orphan     = COLS_ODD && last_col;
        pair_wr    = accept && !col[0] && !orphan;
        lb_wr      = accept &&  col[0] && (state == EVEN_ROW);
        produce    = accept &&  col[0] && (state == ODD_ROW);
        pair_max   = max2(pair_reg, s.in_data);
        tile_max   = max2(line_buf[col[3:1]], pair_max);
    end

    always_comb begin
        state_next = state;
        row_next   = row;
        col_next   = col;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = EVEN_ROW;
                    row_next   = 4'd0;
                    col_next   = 4'd0;
                end
            end
            EVEN_ROW, ODD_ROW: begin
                if (accept) begin
                    if (last_col) begin
                        col_next = 4'd0;
                        if (last_row) begin
                            state_next = FLUSH;
                            row_next   = 4'd0;
                        end else begin
                            row_next   = row + 4'd1;
                            state_next = (state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                        end
                    end else begin
                        col_next = col + 4'd1;
                    end
                end
            end
            FLUSH: begin
                // Hold off completion until the final pooled pixel is taken.
                if (!vld_p1) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            row          <= 4'd0;
            col          <= 4'd0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_next;
            row          <= row_next;
            col          <= col_next;
            frame_done_q <= done_next;
        end
    end

    // ---- stage p1: pair/line-buffer state and output register ----
    always_ff @(posedge clock) begin
        if (reset) begin
            pair_reg <= '0;
            for (int i = 0; i < 8; i++) begin
                line_buf[i] <= '0;
            end
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            if (pair_wr) begin
                pair_reg <= s.in_data;
            end
            if (lb_wr) begin
                line_buf[col[3:1]] <= pair_max;
            end
            // A new result may replace one being accepted in the same cycle.
            if (produce) begin
                vld_p1  <= 1'b1;
                data_p1 <= tile_max;
            end else if (s.out_ready) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign s.in_ready  = in_ready_c;
    assign s.out_valid = vld_p1;
    assign s.out_data  = data_p1;
    assign busy        = (state != IDLE);
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_max_pool2x2.sv
// -----------------------------------------------------------------------------
// tb_max_pool2x2
// Directed bench for max_pool2x2. Two instances: 4x4 and 5x5 frames, selected
// by 'sel'. Inputs change 2 time units after the rising edge; handshakes and
// outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_max_pool2x2;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       sel;
    logic       drv_valid;
    logic [7:0] drv_data;
    logic       out_ready = 1'b1;
    int         rdy_mode  = 0;

    logic busy4, busy5, fd4, fd5;

    max_pool2x2_if #(.DATA_W(8)) if4 ();
    max_pool2x2_if #(.DATA_W(8)) if5 ();

    assign if4.in_valid  = drv_valid && !sel;
    assign if4.in_data   = drv_data;
    assign if4.out_ready = out_ready;
    assign if5.in_valid  = drv_valid && sel;
    assign if5.in_data   = drv_data;
    assign if5.out_ready = out_ready;

    max_pool2x2 #(.COLS(4), .ROWS(4), .DATA_W(8)) u_dut4 (
        .clock      (clock),
        .reset      (reset),
        .start      (start && !sel),
        .busy       (busy4),
        .frame_done (fd4),
        .s          (if4)
    );

    max_pool2x2 #(.COLS(5), .ROWS(5), .DATA_W(8)) u_dut5 (
        .clock      (clock),
        .reset      (reset),
        .start      (start && sel),
        .busy       (busy5),
        .frame_done (fd5),
        .s          (if5)
    );

    logic       cur_in_ready, cur_out_valid, cur_busy, cur_frame_done;
    logic [7:0] cur_out_data;
    assign cur_in_ready   = sel ? if5.in_ready  : if4.in_ready;
    assign cur_out_valid  = sel ? if5.out_valid : if4.out_valid;
    assign cur_out_data   = sel ? if5.out_data  : if4.out_data;
    assign cur_busy       = sel ? busy5 : busy4;
    assign cur_frame_done = sel ? fd5   : fd4;

    always #5 clock = ~clock;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] got_q[$];
    int         done_cnt;
    int         acc_cnt;
    int         outs_at_done;
    int         acc_at_done;
    int         stalls;
    logic [7:0] uv [16];

    // Consumer ready pattern: 0 = always ready, 1 = toggling, 2 = held low.
    always @(posedge clock) begin
        #2;
        case (rdy_mode)
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Output collector and backpressure watch.
    always @(negedge clock) begin
        if (cur_out_valid && out_ready) got_q.push_back(cur_out_data);
        if (drv_valid && cur_in_ready) acc_cnt++;
        if (cur_frame_done) begin
            done_cnt++;
            outs_at_done = got_q.size();
            acc_at_done  = acc_cnt;
        end
        if (cur_out_valid && !out_ready) begin
            n_cmp++;
            assert (cur_in_ready === 1'b0) else begin
                n_fail++;
                $error("FAIL backpressure_in_ready: observed %0b expected 0", cur_in_ready);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        done_cnt     = 0;
        acc_cnt      = 0;
        outs_at_done = -1;
        acc_at_done  = -1;
        stalls       = 0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] v);
        logic ok;
        ok        = 1'b0;
        drv_valid = 1'b1;
        drv_data  = v;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (cur_in_ready) begin
                @(posedge clock); #2;
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        drv_valid = 1'b0;
        chk("in_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (cur_frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("frame_done_seen", {31'd0, seen}, 32'd1);
        repeat (3) @(posedge clock);
        #2;
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        chk({tag, "_count"}, got_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) chk($sformatf("%s_out%0d", tag, i), {24'd0, got_q[i]}, {24'd0, e[i]});
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        sel       = 1'b0;
        drv_valid = 1'b0;
        drv_data  = 8'd0;
        uv = '{8'h01, 8'hFF, 8'h00, 8'h00,
               8'h80, 8'h7F, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00};
        clear_mon();
        repeat (3) @(posedge clock);
        #2;
        chk("rst_in_ready",   {31'd0, cur_in_ready},   32'd0);
        chk("rst_out_valid",  {31'd0, cur_out_valid},  32'd0);
        chk("rst_out_data",   {24'd0, cur_out_data},   32'd0);
        chk("rst_busy",       {31'd0, cur_busy},       32'd0);
        chk("rst_frame_done", {31'd0, cur_frame_done}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #2;

        // 4x4 ramp, consumer always ready
        clear_mon();
        start_pulse();
        chk("start_busy",     {31'd0, cur_busy},     32'd1);
        chk("start_in_ready", {31'd0, cur_in_ready}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            send_pixel(8'(i));
            if (i == 5) begin
                chk("latency_out_valid", {31'd0, cur_out_valid}, 32'd1);
                chk("latency_out_data",  {24'd0, cur_out_data},  32'd5);
            end
        end
        wait_done();
        chk("ramp_stalls", stalls, 32'd0);
        chk_outs("ramp", 8'd5, 8'd7, 8'd13, 8'd15);
        chk("ramp_done_cnt", done_cnt, 32'd1);
        chk("ramp_outs_before_done", outs_at_done, 32'd4);
        chk("ramp_busy_after", {31'd0, cur_busy}, 32'd0);

        // 4x4 ramp, consumer toggling ready
        rdy_mode = 1;
        clear_mon();
        start_pulse();
        for (int i = 0; i < 16; i++) send_pixel(8'(i));
        wait_done();
        chk_outs("toggle", 8'd5, 8'd7, 8'd13, 8'd15);
        chk("toggle_done_cnt", done_cnt, 32'd1);
        chk("toggle_outs_before_done", outs_at_done, 32'd4);
        rdy_mode = 0;
        @(posedge clock); #2;

        // 5x5 ramp: odd width and height
        sel = 1'b1;
        clear_mon();
        start_pulse();
        for (int i = 0; i < 25; i++) send_pixel(8'(i));
        wait_done();
        chk_outs("odd5", 8'd6, 8'd8, 8'd16, 8'd18);
        chk("odd5_accepted_before_done", acc_at_done, 32'd25);
        chk("odd5_done_cnt", done_cnt, 32'd1);
        sel = 1'b0;
        @(posedge clock); #2;

        // unsigned compare: 0x01/0xFF/0x80/0x7F tile and all-zero tiles
        clear_mon();
        start_pulse();
        for (int i = 0; i < 16; i++) send_pixel(uv[i]);
        wait_done();
        chk_outs("unsigned", 8'hFF, 8'h00, 8'h00, 8'h00);

        // reset mid-frame with an output pending
        rdy_mode = 2;
        @(posedge clock); #2;
        clear_mon();
        start_pulse();
        for (int i = 0; i < 6; i++) send_pixel(8'(i));
        chk("pending_out_valid", {31'd0, cur_out_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clock); #2;
        chk("midrst_in_ready",   {31'd0, cur_in_ready},   32'd0);
        chk("midrst_out_valid",  {31'd0, cur_out_valid},  32'd0);
        chk("midrst_out_data",   {24'd0, cur_out_data},   32'd0);
        chk("midrst_busy",       {31'd0, cur_busy},       32'd0);
        chk("midrst_frame_done", {31'd0, cur_frame_done}, 32'd0);
        reset = 1'b0;
        rdy_mode = 0;
        repeat (5) @(posedge clock);
        #2;
        chk("midrst_no_done", done_cnt, 32'd0);
        chk("midrst_no_outputs", got_q.size(), 32'd0);
        clear_mon();
        start_pulse();
        for (int i = 0; i < 16; i++) send_pixel(8'(i));
        wait_done();
        chk_outs("after_rst", 8'd5, 8'd7, 8'd13, 8'd15);
        chk("after_rst_done_cnt", done_cnt, 32'd1);

        // start held high mid-frame must be ignored
        clear_mon();
        start_pulse();
        for (int i = 0; i < 16; i++) begin
            start = (i >= 6 && i <= 9);
            send_pixel(8'(i));
        end
        start = 1'b0;
        wait_done();
        chk_outs("restart", 8'd5, 8'd7, 8'd13, 8'd15);
        chk("restart_done_cnt", done_cnt, 32'd1);
        chk("restart_accepted", acc_at_done, 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
